exec_sequencer: RTL and testbench

- Multi-cycle control FSM for the TiniSOC core.
- Sequences fetch, decode, execute, memory and writeback phases.
- Drives the per-stage enables, including enable_execute into the alu, and the data-memory read/write strobes.
- Handles the instruction- and data-memory ready handshakes with a timeout, counts retired instructions, and stops on illegal opcodes or memory timeouts.

---
 rtl/exec_sequencer.sv | 175 +++++++++++++++++
 tb/tb_exec_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the TiniSOC core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, issues the per-stage
// enables and data-memory strobes, bounds every memory wait with a timeout and
// counts retired instructions. Illegal opcodes and timeouts park it in ERROR.
module exec_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic [5:0]         opcode,
    input  logic [7:0]         sub_op_ls,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               enable_fetch,
    output logic               enable_decode,
    output logic               enable_execute,
    output logic               enable_mem,
    output logic               enable_writeback,
    output logic               mem_read,
    output logic               mem_write,
    output logic               pc_update,
    output logic               busy,
    output logic               err_illegal,
    output logic               err_timeout,
    output logic [COUNT_W-1:0] instr_count
);

    // Major opcode encodings
    localparam logic [5:0] OP_LWI     = 6'h02;
    localparam logic [5:0] OP_SWI     = 6'h0A;
    localparam logic [5:0] OP_TY_LS   = 6'h1C;
    localparam logic [5:0] OP_TY_BASE = 6'h20;
    localparam logic [5:0] OP_MOVI    = 6'h22;
    localparam logic [5:0] OP_JJ      = 6'h24;
    localparam logic [5:0] OP_TY_B    = 6'h26;
    localparam logic [5:0] OP_ADDI    = 6'h28;
    localparam logic [5:0] OP_XORI    = 6'h2B;
    localparam logic [5:0] OP_ORI     = 6'h2C;
    // Load/store sub-operations under TY_LS
    localparam logic [7:0] SUB_LW     = 8'h02;
    localparam logic [7:0] SUB_SW     = 8'h0A;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        C_ALU, C_LOAD, C_STORE, C_CTRL
    } class_t;

    state_t              state_reg;
    class_t              class_reg;
    logic [WAIT_W-1:0]   wait_reg;
    logic                err_illegal_reg;
    logic                err_timeout_reg;
    logic [COUNT_W-1:0]  count_reg;

    class_t              dec_class;
    logic                dec_legal;
    logic                retire;

    // Classify the decoder fields; anything unrecognised is illegal
    always_comb begin
        dec_class = C_ALU;
        dec_legal = 1'b1;
        case (opcode)
            OP_TY_BASE, OP_ADDI, OP_ORI, OP_XORI, OP_MOVI: dec_class = C_ALU;
            OP_LWI:                                        dec_class = C_LOAD;
            OP_SWI:                                        dec_class = C_STORE;
            OP_TY_B, OP_JJ:                                dec_class = C_CTRL;
            OP_TY_LS: begin
                if (sub_op_ls == SUB_LW)      dec_class = C_LOAD;
                else if (sub_op_ls == SUB_SW) dec_class = C_STORE;
                else                          dec_legal = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Retire point: WB, CTRL in EXEC, or STORE when data memory acks; a reset
    // in the same cycle aborts the instruction
    assign retire = !reset &&
                    ((state_reg == S_WB) ||
                     (state_reg == S_EXEC && class_reg == C_CTRL) ||
                     (state_reg == S_MEM && class_reg == C_STORE && dmem_ready));

    // Sequencer state, instruction class, wait counter, sticky errors, retire count
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            class_reg       <= C_ALU;
            wait_reg        <= '0;
            err_illegal_reg <= 1'b0;
            err_timeout_reg <= 1'b0;
            count_reg       <= '0;
        end else begin
            if (retire)
                count_reg <= count_reg + COUNT_W'(1);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_FETCH;
                        wait_reg  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_reg       <= S_ERROR;
                        err_timeout_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        class_reg <= dec_class;
                        state_reg <= S_EXEC;
                    end else begin
                        state_reg       <= S_ERROR;
                        err_illegal_reg <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // Both MEM entry and the CTRL return to FETCH need a fresh wait count
                    wait_reg <= '0;
                    case (class_reg)
                        C_ALU:          state_reg <= S_WB;
                        C_LOAD, C_STORE: state_reg <= S_MEM;
                        default:        state_reg <= halt ? S_IDLE : S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        wait_reg <= '0;
                        if (class_reg == C_LOAD) state_reg <= S_WB;
                        else                     state_reg <= halt ? S_IDLE : S_FETCH;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_reg       <= S_ERROR;
                        err_timeout_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    wait_reg  <= '0;
                    state_reg <= halt ? S_IDLE : S_FETCH;
                end
                S_ERROR: state_reg <= S_ERROR;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign enable_fetch     = (state_reg == S_FETCH);
    assign enable_decode    = (state_reg == S_DECODE);
    assign enable_execute   = (state_reg == S_EXEC);
    assign enable_mem       = (state_reg == S_MEM);
    assign enable_writeback = (state_reg == S_WB);
    assign mem_read         = (state_reg == S_MEM) && (class_reg == C_LOAD);
    assign mem_write        = (state_reg == S_MEM) && (class_reg == C_STORE);
    assign busy             = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    assign pc_update        = retire;
    assign err_illegal      = err_illegal_reg;
    assign err_timeout      = err_timeout_reg;
    assign instr_count      = count_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer. Inputs change and outputs are sampled
// just after the falling edge; "frame f" is the f-th cycle after the start cycle.
module tb_exec_sequencer;

    localparam logic [5:0] OP_LWI   = 6'h02;
    localparam logic [5:0] OP_SWI   = 6'h0A;
    localparam logic [5:0] OP_TY_LS = 6'h1C;
    localparam logic [5:0] OP_TY_B  = 6'h26;
    localparam logic [5:0] OP_ADDI  = 6'h28;
    localparam logic [7:0] SUB_SW   = 8'h0A;

    logic       clock = 1'b0;
    logic       reset, start, halt, imem_ready, dmem_ready;
    logic [5:0] opcode;
    logic [7:0] sub_op_ls;
    logic       enable_fetch, enable_decode, enable_execute, enable_mem, enable_writeback;
    logic       mem_read, mem_write, pc_update, busy, err_illegal, err_timeout;
    logic [3:0] instr_count;

    int vectors = 0;
    int miscompares = 0;
    int excl_viol = 0;

    exec_sequencer #(.MEM_TIMEOUT(15), .COUNT_W(4)) dut (
        .clock(clock), .reset(reset), .start(start), .halt(halt),
        .opcode(opcode), .sub_op_ls(sub_op_ls),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_mem(enable_mem),
        .enable_writeback(enable_writeback), .mem_read(mem_read),
        .mem_write(mem_write), .pc_update(pc_update), .busy(busy),
        .err_illegal(err_illegal), .err_timeout(err_timeout),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // More than one stage enable in a cycle is a violation
    always @(negedge clock)
        if ($countones({enable_fetch, enable_decode, enable_execute,
                        enable_mem, enable_writeback}) > 1)
            excl_viol++;

    task automatic do_reset();
        @(negedge clock);
        reset = 1; start = 0; halt = 0; imem_ready = 0; dmem_ready = 0;
        opcode = 6'h00; sub_op_ls = 8'h00;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        do_reset();
        #1;
        outs = {enable_fetch, enable_decode, enable_execute, enable_mem, enable_writeback,
                mem_read, mem_write, pc_update, busy, err_illegal, err_timeout};
        vectors++;
        if (outs !== 11'b0 || instr_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got outs=%b count=%0d, expected outs=0 count=0", outs, instr_count);
        end
    endtask

    task automatic test_alu_stream();
        logic [11:0] pc_mask = '0;
        int ex_cnt = 0;
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; opcode = OP_ADDI;
        for (int f = 1; f <= 12; f++) begin
            @(negedge clock); start = 0; halt = (f == 12);
            #1;
            pc_mask[f-1] = pc_update;
            if (enable_execute) ex_cnt++;
        end
        @(negedge clock); halt = 0; #1;
        vectors++;
        if (pc_mask !== 12'b1000_1000_1000) begin
            miscompares++;
            $display("FAIL alu_pc_pulses: got %b, expected %b", pc_mask, 12'b1000_1000_1000);
        end
        vectors++;
        if (ex_cnt !== 3) begin
            miscompares++;
            $display("FAIL alu_exec_cycles: got %0d, expected 3", ex_cnt);
        end
        vectors++;
        if (instr_count !== 4'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_count_idle: got count=%0d busy=%b, expected count=3 busy=0", instr_count, busy);
        end
    endtask

    task automatic test_load_store();
        logic [7:0] pc_mask = '0;
        logic [3:0] pc_mask_s = '0;
        int rd_cnt = 0, wb_cnt = 0, wr_cnt = 0, wbs_cnt = 0;
        logic mem_ok = 1'b0;
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; opcode = OP_LWI;
        for (int f = 1; f <= 8; f++) begin
            @(negedge clock); start = 0; dmem_ready = (f >= 7); halt = (f == 8);
            #1;
            pc_mask[f-1] = pc_update;
            if (mem_read) rd_cnt++;
            if (enable_writeback) wb_cnt++;
            if (f == 4) mem_ok = enable_mem && mem_read && !mem_write;
        end
        vectors++;
        if (mem_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL load_mem_entry: got mem_ok=%b, expected 1", mem_ok);
        end
        vectors++;
        if (rd_cnt !== 4 || wb_cnt !== 1) begin
            miscompares++;
            $display("FAIL load_wait: got mem_read=%0d wb=%0d, expected 4 and 1", rd_cnt, wb_cnt);
        end
        vectors++;
        if (pc_mask !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL load_retire: got %b, expected %b", pc_mask, 8'b1000_0000);
        end
        // Store via TY_LS/SW with immediate ready; halt held high throughout
        @(negedge clock); start = 1; halt = 0; dmem_ready = 1; opcode = OP_TY_LS; sub_op_ls = SUB_SW;
        for (int f = 1; f <= 4; f++) begin
            @(negedge clock); start = 0; halt = 1;
            #1;
            pc_mask_s[f-1] = pc_update;
            if (mem_write) wr_cnt++;
            if (enable_writeback) wbs_cnt++;
        end
        @(negedge clock); halt = 0; #1;
        vectors++;
        if (wr_cnt !== 1 || wbs_cnt !== 0 || pc_mask_s !== 4'b1000) begin
            miscompares++;
            $display("FAIL store_path: got wr=%0d wb=%0d pc=%b, expected 1 0 1000", wr_cnt, wbs_cnt, pc_mask_s);
        end
        vectors++;
        if (instr_count !== 4'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL store_count: got count=%0d busy=%b, expected 2 0", instr_count, busy);
        end
    endtask

    task automatic test_halt_boundary();
        logic mem_seen = 1'b0, wb_retire = 1'b0;
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; dmem_ready = 1; opcode = OP_LWI;
        for (int f = 1; f <= 5; f++) begin
            @(negedge clock); start = 0; halt = (f == 3) || (f == 5);
            #1;
            if (f == 4) mem_seen = enable_mem;
            if (f == 5) wb_retire = enable_writeback && pc_update;
        end
        vectors++;
        if (mem_seen !== 1'b1 || wb_retire !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_in_exec: got mem=%b wb_retire=%b, expected 1 1", mem_seen, wb_retire);
        end
        @(negedge clock); halt = 0; start = 1; #1;
        vectors++;
        if (busy !== 1'b0 || instr_count !== 4'd1) begin
            miscompares++;
            $display("FAIL halt_in_wb: got busy=%b count=%0d, expected 0 1", busy, instr_count);
        end
        @(negedge clock); start = 0; #1;
        vectors++;
        if (enable_fetch !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_resume: got enable_fetch=%b, expected 1", enable_fetch);
        end
    endtask

    task automatic test_illegal();
        logic ex_any = 1'b0;
        logic [2:0] err_view = '0;
        logic [1:0] err_late = '0;
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; opcode = OP_TY_LS; sub_op_ls = 8'hFF;
        for (int f = 1; f <= 6; f++) begin
            @(negedge clock); start = (f == 4);
            #1;
            if (enable_execute) ex_any = 1'b1;
            if (f == 3) err_view = {err_illegal, busy,
                                    enable_fetch | enable_decode | enable_mem | enable_writeback};
            if (f == 6) err_late = {err_illegal, busy};
        end
        vectors++;
        if (err_view !== 3'b100) begin
            miscompares++;
            $display("FAIL illegal_error: got {err,busy,en}=%b, expected 100", err_view);
        end
        vectors++;
        if (ex_any !== 1'b0 || instr_count !== 4'd0 || err_late !== 2'b10) begin
            miscompares++;
            $display("FAIL illegal_sticky: got exec=%b count=%0d {err,busy}=%b, expected 0 0 10", ex_any, instr_count, err_late);
        end
        do_reset(); #1;
        vectors++;
        if (err_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_reset: got err_illegal=%b, expected 0", err_illegal);
        end
        // Unlisted major opcode
        @(negedge clock); start = 1; imem_ready = 1; opcode = 6'h3F;
        for (int f = 1; f <= 3; f++) begin
            @(negedge clock); start = 0; #1;
        end
        vectors++;
        if (err_illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_opcode: got err_illegal=%b, expected 1", err_illegal);
        end
    endtask

    task automatic test_timeout();
        int fetch_cnt = 0, mem_cnt = 0;
        logic early_err = 1'b1;
        logic [2:0] view = '0;
        do_reset();
        @(negedge clock); start = 1;
        for (int f = 1; f <= 16; f++) begin
            @(negedge clock); start = 0; #1;
            if (enable_fetch) fetch_cnt++;
            if (f == 15) early_err = err_timeout;
            if (f == 16) view = {err_timeout, busy, enable_fetch};
        end
        vectors++;
        if (fetch_cnt !== 15 || early_err !== 1'b0 || view !== 3'b100) begin
            miscompares++;
            $display("FAIL fetch_timeout: got fetch=%0d early=%b view=%b, expected 15 0 100", fetch_cnt, early_err, view);
        end
        // Ready arriving on the last allowed FETCH cycle still proceeds
        do_reset();
        @(negedge clock); start = 1;
        for (int f = 1; f <= 16; f++) begin
            @(negedge clock); start = 0; imem_ready = (f == 15); #1;
        end
        vectors++;
        if (enable_decode !== 1'b1 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_last_ready: got decode=%b err=%b, expected 1 0", enable_decode, err_timeout);
        end
        // Data memory never acks
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; opcode = OP_LWI;
        for (int f = 1; f <= 19; f++) begin
            @(negedge clock); start = 0; #1;
            if (mem_read) mem_cnt++;
        end
        vectors++;
        if (mem_cnt !== 15 || err_timeout !== 1'b1 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_timeout: got mem=%0d err=%b rd=%b, expected 15 1 0", mem_cnt, err_timeout, mem_read);
        end
    endtask

    task automatic test_wrap();
        int pc_cnt = 0;
        logic [3:0] mid_count = '0;
        logic first_pc = 1'b0;
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; opcode = OP_TY_B;
        for (int f = 1; f <= 48; f++) begin
            @(negedge clock); start = 0; halt = (f == 48); #1;
            if (pc_update) pc_cnt++;
            if (f == 3) first_pc = pc_update;
            if (f == 46) mid_count = instr_count;
        end
        @(negedge clock); halt = 0; #1;
        vectors++;
        if (pc_cnt !== 16 || first_pc !== 1'b1) begin
            miscompares++;
            $display("FAIL ctrl_retires: got %0d first=%b, expected 16 1", pc_cnt, first_pc);
        end
        vectors++;
        if (mid_count !== 4'd15 || instr_count !== 4'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL count_wrap: got mid=%0d final=%0d busy=%b, expected 15 0 0", mid_count, instr_count, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] outs;
        logic in_mem = 1'b0;
        do_reset();
        @(negedge clock); start = 1; imem_ready = 1; opcode = OP_SWI;
        for (int f = 1; f <= 4; f++) begin
            @(negedge clock); start = 0; #1;
            if (f == 4) in_mem = enable_mem && mem_write;
        end
        @(negedge clock); reset = 1; dmem_ready = 1; #1;
        vectors++;
        if (in_mem !== 1'b1 || pc_update !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_mem_retire: got in_mem=%b pc=%b, expected 1 0", in_mem, pc_update);
        end
        @(negedge clock); reset = 0; dmem_ready = 0; #1;
        outs = {enable_fetch, enable_decode, enable_execute, enable_mem, enable_writeback,
                mem_read, mem_write, pc_update, busy, err_illegal, err_timeout};
        vectors++;
        if (outs !== 11'b0 || instr_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_in_mem_idle: got outs=%b count=%0d, expected 0 0", outs, instr_count);
        end
    endtask

    initial begin
        reset = 1; start = 0; halt = 0; imem_ready = 0; dmem_ready = 0;
        opcode = 6'h00; sub_op_ls = 8'h00;
        test_reset();
        test_alu_stream();
        test_load_store();
        test_halt_boundary();
        test_illegal();
        test_timeout();
        test_wrap();
        test_reset_mid();
        vectors++;
        if (excl_viol !== 0) begin
            miscompares++;
            $display("FAIL enable_exclusive: got %0d violating cycles, expected 0", excl_viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
